matrix_operand_loader: RTL

- Upstream operand stage for the matrix arithmetic units; the subtractor is the first consumer.
- Accepts a serial stream of 8-bit elements over a valid/ready handshake: first all of matrix A, then all of matrix B.
- Packs the elements into two 200-bit operand registers and signals completion.
- Outputs are registered and held stable, so downstream combinational operators can sample them directly.

---
 rtl/matrix_operand_loader.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/matrix_operand_loader.sv
// matrix_operand_loader
// Operand stage for the matrix arithmetic units. It collects a serial stream of
// 8-bit elements (all of A, then all of B, row-major) over a valid/ready
// handshake and packs them into two 200-bit operand registers that are held
// stable for downstream combinational operators.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-high reset
//   start          begin a load (sampled only in IDLE)
//   size_in        size code: 00=2x2, 01=3x3, 10=4x4, 11=5x5
//   data_in        element data
//   data_valid     data_in valid this cycle
//   data_ready     loader accepts an element this cycle (state decode)
//   matrix_A/B     packed operands, element i at bits [i*8+7:i*8]
//   matrix_size    size code latched at start
//   busy           high in LOAD_A, LOAD_B, DONE
//   done           one-cycle pulse when both matrices are complete
//   operands_valid matrix_A/B/size hold a complete load
module matrix_operand_loader #(
  parameter int unsigned ELEM_W    = 8,
  parameter int unsigned MAX_ELEMS = 25
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [1:0]                    size_in,
  input  logic [ELEM_W-1:0]             data_in,
  input  logic                          data_valid,
  output logic                          data_ready,
  output logic [MAX_ELEMS*ELEM_W-1:0]   matrix_A,
  output logic [MAX_ELEMS*ELEM_W-1:0]   matrix_B,
  output logic [1:0]                    matrix_size,
  output logic                          busy,
  output logic                          done,
  output logic                          operands_valid
);

  localparam int unsigned IDX_W  = 5;
  localparam int unsigned BASE_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_A = 2'd1,
    LOAD_B = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    index_q;
  logic [IDX_W-1:0]    last_idx;
  logic [BASE_W-1:0]   bit_base;
  logic                accept;
  logic                last_beat;
  logic                load_start;
  logic                wr_a;
  logic                wr_b;

  // Handshake, busy and done are pure decodes of the state register.
  assign data_ready = (state_q == LOAD_A) || (state_q == LOAD_B);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);

  assign accept    = data_valid && data_ready;
  assign last_beat = (index_q == last_idx);
  assign bit_base  = BASE_W'(index_q) * BASE_W'(ELEM_W);

  // Last index of a matrix, from the size latched at start.
  always_comb begin
    last_idx = IDX_W'(24);
    case (matrix_size)
      2'b00:   last_idx = IDX_W'(3);
      2'b01:   last_idx = IDX_W'(8);
      2'b10:   last_idx = IDX_W'(15);
      default: last_idx = IDX_W'(24);
    endcase
  end

  // Next-state and datapath write enables.
  always_comb begin
    state_d    = state_q;
    load_start = 1'b0;
    wr_a       = 1'b0;
    wr_b       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load_start = 1'b1;
          state_d    = LOAD_A;
        end
      end
      LOAD_A: begin
        if (accept) begin
          wr_a = 1'b1;
          if (last_beat) state_d = LOAD_B;
        end
      end
      LOAD_B: begin
        if (accept) begin
          wr_b = 1'b1;
          if (last_beat) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register and operand datapath.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      index_q        <= '0;
      matrix_A       <= '0;
      matrix_B       <= '0;
      matrix_size    <= '0;
      operands_valid <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_start) begin
        // Clearing both operands keeps unused positions zero for smaller loads.
        matrix_size    <= size_in;
        matrix_A       <= '0;
        matrix_B       <= '0;
        operands_valid <= 1'b0;
        index_q        <= '0;
      end
      if (wr_a) begin
        matrix_A[bit_base +: ELEM_W] <= data_in;
        index_q <= last_beat ? '0 : index_q + IDX_W'(1);
      end
      if (wr_b) begin
        matrix_B[bit_base +: ELEM_W] <= data_in;
        index_q <= last_beat ? '0 : index_q + IDX_W'(1);
        // Raised with the final beat so it is already high alongside done.
        if (last_beat) operands_valid <= 1'b1;
      end
    end
  end

endmodule
